// File: rtl/wbs_pci_arbiter_pkg.sv
// wbs_pci_arbiter_pkg
//   Shared definitions for the PCI-bridge WISHBONE slave-port arbiter:
//   WISHBONE CTI/BTE encodings, the arbiter state encoding, the bus field
//   widths, and a helper that sizes the flattened per-requester buses.
package wbs_pci_arbiter_pkg;

   localparam int unsigned ADR_W = 32;
   localparam int unsigned DAT_W = 32;
   localparam int unsigned SEL_W = 4;
   localparam int unsigned CTI_W = 3;
   localparam int unsigned BTE_W = 2;

   typedef enum logic [2:0] {
      CTI_CLASSIC = 3'b000,
      CTI_CONST   = 3'b001,
      CTI_INCR    = 3'b010,
      CTI_EOB     = 3'b111
   } cti_e;

   typedef enum logic [1:0] {
      BTE_LINEAR = 2'b00,
      BTE_WRAP4  = 2'b01,
      BTE_WRAP8  = 2'b10,
      BTE_WRAP16 = 2'b11
   } bte_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWNED = 2'd1,
      ST_ABORT = 2'd2
   } arb_state_e;

   // Width of a bus that packs n requesters' w-bit fields side by side.
   function automatic int unsigned flat_w(input int unsigned n, input int unsigned w);
      return n * w;
   endfunction

endpackage

// File: rtl/wbs_pci_arbiter_if.sv
// wbs_pci_arbiter_if
//   Bundles the local requester buses (flattened, requester k in slice k)
//   and the bridge WBS_* slave port.
//   modport master : the arbiter (drives REQ_*_O and WBS_*_O)
//   modport slave  : the environment (local masters plus bridge)
interface wbs_pci_arbiter_if
   import wbs_pci_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 4
);
   // requester side
   logic [NREQ-1:0]                 REQ_CYC_I;
   logic [NREQ-1:0]                 REQ_STB_I;
   logic [NREQ-1:0]                 REQ_WE_I;
   logic [flat_w(NREQ, ADR_W)-1:0]  REQ_ADR_I;
   logic [flat_w(NREQ, DAT_W)-1:0]  REQ_DAT_I;
   logic [flat_w(NREQ, SEL_W)-1:0]  REQ_SEL_I;
   logic [flat_w(NREQ, CTI_W)-1:0]  REQ_CTI_I;
   logic [flat_w(NREQ, BTE_W)-1:0]  REQ_BTE_I;
   logic [DAT_W-1:0]                REQ_DAT_O;
   logic [NREQ-1:0]                 REQ_ACK_O;
   logic [NREQ-1:0]                 REQ_RTY_O;
   logic [NREQ-1:0]                 REQ_ERR_O;
   // bridge side
   logic [ADR_W-1:0]                WBS_ADR_O;
   logic [DAT_W-1:0]                WBS_DAT_O;
   logic [SEL_W-1:0]                WBS_SEL_O;
   logic                            WBS_CYC_O;
   logic                            WBS_STB_O;
   logic                            WBS_WE_O;
   logic [CTI_W-1:0]                WBS_CTI_O;
   logic [BTE_W-1:0]                WBS_BTE_O;
   logic [DAT_W-1:0]                WBS_DAT_I;
   logic                            WBS_ACK_I;
   logic                            WBS_RTY_I;
   logic                            WBS_ERR_I;

   modport master (
      input  REQ_CYC_I, REQ_STB_I, REQ_WE_I, REQ_ADR_I, REQ_DAT_I, REQ_SEL_I,
             REQ_CTI_I, REQ_BTE_I, WBS_DAT_I, WBS_ACK_I, WBS_RTY_I, WBS_ERR_I,
      output REQ_DAT_O, REQ_ACK_O, REQ_RTY_O, REQ_ERR_O,
             WBS_ADR_O, WBS_DAT_O, WBS_SEL_O, WBS_CYC_O, WBS_STB_O, WBS_WE_O,
             WBS_CTI_O, WBS_BTE_O
   );

   modport slave (
      output REQ_CYC_I, REQ_STB_I, REQ_WE_I, REQ_ADR_I, REQ_DAT_I, REQ_SEL_I,
             REQ_CTI_I, REQ_BTE_I, WBS_DAT_I, WBS_ACK_I, WBS_RTY_I, WBS_ERR_I,
      input  REQ_DAT_O, REQ_ACK_O, REQ_RTY_O, REQ_ERR_O,
             WBS_ADR_O, WBS_DAT_O, WBS_SEL_O, WBS_CYC_O, WBS_STB_O, WBS_WE_O,
             WBS_CTI_O, WBS_BTE_O
   );

endinterface

// File: rtl/wbs_pci_arbiter_rr_pick.sv
// wbs_pci_arbiter_rr_pick
//   Combinational round-robin selector: picks the first set request at or
//   after the pointer, wrapping cyclically.
//   req_i : request bits     ptr_i : priority pointer
//   gnt_o : one-hot winner   idx_o : binary index of winner
module wbs_pci_arbiter_rr_pick
   import wbs_pci_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PW   = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   idx_o
);
   logic [NREQ-1:0] upper;
   logic [NREQ-1:0] cand;

   // Requests at/above the pointer win over the wrapped-around ones; inside
   // the chosen set the lowest index wins.
   always_comb begin
      upper = '0;
      for (int i = 0; i < NREQ; i++) upper[i] = req_i[i] && (i >= int'(ptr_i));
      cand  = (|upper) ? upper : req_i;
      gnt_o = '0;
      idx_o = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            gnt_o    = '0;
            gnt_o[i] = 1'b1;
            idx_o    = PW'(i);
         end
      end
   end

endmodule

// File: rtl/wbs_pci_arbiter.sv
// wbs_pci_arbiter
//   Round-robin arbiter sharing the PCI bridge WISHBONE slave port between
//   up to four local masters. Whole bus cycles are granted (no preemption),
//   responses are routed to the owner only, and a stalled cycle is aborted
//   with a one-cycle ERR after TIMEOUT_CYC unanswered STB cycles.
//   WB_CLK, WB_RST_N : clock, synchronous active-low reset
//   bus              : requester buses + bridge WBS_* port
//   GNT_O            : registered one-hot owner
//   TIMEOUT_CNT_O    : saturating count of aborted cycles
module wbs_pci_arbiter
   import wbs_pci_arbiter_pkg::*;
#(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned TW          = 11
) (
   input  logic              WB_CLK,
   input  logic              WB_RST_N,
   wbs_pci_arbiter_if.master bus,
   output logic [NREQ-1:0]   GNT_O,
   output logic [7:0]        TIMEOUT_CNT_O
);
   localparam int unsigned   PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYC - 1);

   arb_state_e       state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [PW-1:0]    own_q, own_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [TW-1:0]    wd_q, wd_d;
   logic [7:0]       tocnt_q, tocnt_d;
   logic             err_first_q, err_first_d;

   logic [NREQ-1:0]  pick_gnt;
   logic [PW-1:0]    pick_idx;
   logic [PW-1:0]    nxt_ptr;
   logic             owned, aborting, own_cyc, mux_stb, mux_we, rsp_any, stall, expire;
   logic [ADR_W-1:0] mux_adr;
   logic [DAT_W-1:0] mux_dat;
   logic [SEL_W-1:0] mux_sel;
   logic [CTI_W-1:0] mux_cti;
   logic [BTE_W-1:0] mux_bte;

   wbs_pci_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req_i (bus.REQ_CYC_I),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx)
   );

   // Owner mux: gnt_q is zero outside OWNED/ABORT, so everything reads 0
   // whenever nobody holds the bus.
   always_comb begin
      mux_adr = '0;
      mux_dat = '0;
      mux_sel = '0;
      mux_cti = '0;
      mux_bte = '0;
      mux_stb = 1'b0;
      mux_we  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_q[i]) begin
            mux_adr = bus.REQ_ADR_I[i*ADR_W +: ADR_W];
            mux_dat = bus.REQ_DAT_I[i*DAT_W +: DAT_W];
            mux_sel = bus.REQ_SEL_I[i*SEL_W +: SEL_W];
            mux_cti = bus.REQ_CTI_I[i*CTI_W +: CTI_W];
            mux_bte = bus.REQ_BTE_I[i*BTE_W +: BTE_W];
            mux_stb = bus.REQ_STB_I[i];
            mux_we  = bus.REQ_WE_I[i];
         end
      end
   end

   assign owned    = (state_q == ST_OWNED);
   assign aborting = (state_q == ST_ABORT);
   assign own_cyc  = |(bus.REQ_CYC_I & gnt_q);
   assign rsp_any  = bus.WBS_ACK_I | bus.WBS_RTY_I | bus.WBS_ERR_I;

   // CYC/STB are only passed through while OWNED; ABORT forces them low.
   assign bus.WBS_CYC_O = owned & own_cyc;
   assign bus.WBS_STB_O = owned & mux_stb;
   assign bus.WBS_WE_O  = mux_we;
   assign bus.WBS_ADR_O = mux_adr;
   assign bus.WBS_DAT_O = mux_dat;
   assign bus.WBS_SEL_O = mux_sel;
   assign bus.WBS_CTI_O = mux_cti;
   assign bus.WBS_BTE_O = mux_bte;

   assign bus.REQ_DAT_O = bus.WBS_DAT_I;
   assign bus.REQ_ACK_O = owned ? (gnt_q & {NREQ{bus.WBS_ACK_I}}) : '0;
   assign bus.REQ_RTY_O = owned ? (gnt_q & {NREQ{bus.WBS_RTY_I}}) : '0;
   assign bus.REQ_ERR_O = owned                   ? (gnt_q & {NREQ{bus.WBS_ERR_I}}) :
                          (aborting && err_first_q) ? gnt_q : '0;

   assign GNT_O         = gnt_q;
   assign TIMEOUT_CNT_O = tocnt_q;

   // Watchdog: a response in the would-be expiry cycle clears stall, so the
   // beat completes normally instead of aborting.
   assign stall   = owned && bus.WBS_STB_O && !rsp_any;
   assign expire  = (TIMEOUT_CYC != 0) && stall && (wd_q == WD_LAST);
   assign nxt_ptr = (own_q == PW'(NREQ - 1)) ? '0 : own_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      own_d       = own_q;
      ptr_d       = ptr_q;
      tocnt_d     = tocnt_q;
      err_first_d = 1'b0;
      wd_d        = (stall && TIMEOUT_CYC != 0) ? wd_q + 1'b1 : '0;
      case (state_q)
         ST_IDLE: begin
            if (|bus.REQ_CYC_I) begin
               state_d = ST_OWNED;
               gnt_d   = pick_gnt;
               own_d   = pick_idx;
            end
         end
         ST_OWNED, ST_ABORT: begin
            if (!own_cyc) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               ptr_d   = nxt_ptr;
            end else if (owned && expire) begin
               state_d     = ST_ABORT;
               err_first_d = 1'b1;
               if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge WB_CLK) begin
      if (!WB_RST_N) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         own_q       <= '0;
         ptr_q       <= '0;
         wd_q        <= '0;
         tocnt_q     <= '0;
         err_first_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         own_q       <= own_d;
         ptr_q       <= ptr_d;
         wd_q        <= wd_d;
         tocnt_q     <= tocnt_d;
         err_first_q <= err_first_d;
      end
   end

endmodule

// File: tb/tb_wbs_pci_arbiter.sv
// tb_wbs_pci_arbiter
//   Self-checking bench: table of single-beat transactions, hand-written
//   burst / timeout / expiry-race / reset / round-robin sequences, and a
//   response scoreboard that checks every ACK/RTY/ERR seen by requesters.
module tb_wbs_pci_arbiter;
   import wbs_pci_arbiter_pkg::*;

   localparam int unsigned NREQ = 4;
   localparam int unsigned TOC  = 8;
   localparam int unsigned TW   = 4;

   logic            WB_CLK   = 1'b0;
   logic            WB_RST_N = 1'b0;
   logic [NREQ-1:0] GNT_O;
   logic [7:0]      TIMEOUT_CNT_O;

   wbs_pci_arbiter_if #(.NREQ(NREQ)) bus ();

   wbs_pci_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TOC), .TW(TW)) dut (
      .WB_CLK        (WB_CLK),
      .WB_RST_N      (WB_RST_N),
      .bus           (bus),
      .GNT_O         (GNT_O),
      .TIMEOUT_CNT_O (TIMEOUT_CNT_O)
   );

   always #5 WB_CLK = ~WB_CLK;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0]  ack;
      logic [3:0]  rty;
      logic [3:0]  err;
      logic [31:0] dat;
   } resp_t;

   resp_t exp_q[$];
   resp_t got, want;
   bit    mon_en = 1'b0;

   typedef struct {
      int          r;
      logic [31:0] adr;
      logic        we;
      logic [31:0] wdat;
      logic [3:0]  sel;
      logic [31:0] rdat;
      logic [3:0]  gnt;
      logic [3:0]  ack;
      logic [3:0]  rty;
      logic [3:0]  err;
   } vec_t;

   vec_t tbl[4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge WB_CLK);
      #1;
   endtask

   task automatic smp();
      @(negedge WB_CLK);
   endtask

   task automatic drv_req(input int r, input logic cs, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input logic [2:0] cti);
      bus.REQ_CYC_I[r]            = cs;
      bus.REQ_STB_I[r]            = cs;
      bus.REQ_WE_I[r]             = we;
      bus.REQ_ADR_I[r*32 +: 32]   = adr;
      bus.REQ_DAT_I[r*32 +: 32]   = dat;
      bus.REQ_SEL_I[r*4 +: 4]     = sel;
      bus.REQ_CTI_I[r*3 +: 3]     = cti;
      bus.REQ_BTE_I[r*2 +: 2]     = 2'b00;
   endtask

   task automatic brg(input logic ack, input logic rty, input logic err, input logic [31:0] dat);
      bus.WBS_ACK_I = ack;
      bus.WBS_RTY_I = rty;
      bus.WBS_ERR_I = err;
      bus.WBS_DAT_I = dat;
   endtask

   task automatic push(input logic [3:0] ack, input logic [3:0] rty, input logic [3:0] err,
                       input logic [31:0] dat);
      exp_q.push_back('{ack: ack, rty: rty, err: err, dat: dat});
   endtask

   // Scoreboard: every cycle a requester sees a response it must match the
   // oldest expectation.
   always @(negedge WB_CLK) begin
      if (mon_en) begin
         got = '{ack: bus.REQ_ACK_O, rty: bus.REQ_RTY_O, err: bus.REQ_ERR_O, dat: bus.REQ_DAT_O};
         if (|{got.ack, got.rty, got.err}) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL resp_unexpected: got ack=%b rty=%b err=%b dat=%h required none",
                        got.ack, got.rty, got.err, got.dat);
            end else begin
               want = exp_q.pop_front();
               if (got !== want) begin
                  errors++;
                  $display("FAIL resp: got ack=%b rty=%b err=%b dat=%h required ack=%b rty=%b err=%b dat=%h",
                           got.ack, got.rty, got.err, got.dat, want.ack, want.rty, want.err, want.dat);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{r: 1, adr: 32'h0000_1000, we: 1'b0, wdat: 32'h0, sel: 4'hF, rdat: 32'hDEAD_BEEF,
                 gnt: 4'b0010, ack: 4'b0010, rty: 4'b0000, err: 4'b0000};
      tbl[1] = '{r: 0, adr: 32'h0000_2004, we: 1'b1, wdat: 32'h1234_5678, sel: 4'hF, rdat: 32'h1111_0000,
                 gnt: 4'b0001, ack: 4'b0001, rty: 4'b0000, err: 4'b0000};
      tbl[2] = '{r: 3, adr: 32'hFFFF_FFFC, we: 1'b1, wdat: 32'hA5A5_A5A5, sel: 4'b0011, rdat: 32'h0,
                 gnt: 4'b1000, ack: 4'b0000, rty: 4'b1000, err: 4'b0000};
      tbl[3] = '{r: 2, adr: 32'h8000_0000, we: 1'b0, wdat: 32'h0, sel: 4'b1000, rdat: 32'hCAFE_F00D,
                 gnt: 4'b0100, ack: 4'b0000, rty: 4'b0000, err: 4'b0100};

      bus.REQ_CYC_I = '0; bus.REQ_STB_I = '0; bus.REQ_WE_I = '0;
      bus.REQ_ADR_I = '0; bus.REQ_DAT_I = '0; bus.REQ_SEL_I = '0;
      bus.REQ_CTI_I = '0; bus.REQ_BTE_I = '0;
      brg(1'b0, 1'b0, 1'b0, 32'h0);

      // reset state
      nxt(); nxt(); smp();
      chk("rst_gnt",   32'(GNT_O), 32'd0);
      chk("rst_tocnt", 32'(TIMEOUT_CNT_O), 32'd0);
      chk("rst_cyc",   32'(bus.WBS_CYC_O), 32'd0);
      nxt(); WB_RST_N = 1'b1; mon_en = 1'b1; smp();

      // single-beat transactions from the vector table
      for (int v = 0; v < 4; v++) begin
         nxt();
         drv_req(tbl[v].r, 1'b1, tbl[v].we, tbl[v].adr, tbl[v].wdat, tbl[v].sel, CTI_CLASSIC);
         smp();
         chk("pre_gnt", 32'(GNT_O), 32'd0);
         chk("pre_cyc", 32'(bus.WBS_CYC_O), 32'd0);
         chk("pre_adr", bus.WBS_ADR_O, 32'd0);
         nxt(); smp();
         chk("gnt",  32'(GNT_O), 32'(tbl[v].gnt));
         chk("cyc",  32'(bus.WBS_CYC_O), 32'd1);
         chk("adr",  bus.WBS_ADR_O, tbl[v].adr);
         chk("we",   32'(bus.WBS_WE_O), 32'(tbl[v].we));
         chk("wdat", bus.WBS_DAT_O, tbl[v].wdat);
         chk("sel",  32'(bus.WBS_SEL_O), 32'(tbl[v].sel));
         nxt();
         brg(|tbl[v].ack, |tbl[v].rty, |tbl[v].err, tbl[v].rdat);
         push(tbl[v].ack, tbl[v].rty, tbl[v].err, tbl[v].rdat);
         smp();
         nxt();
         brg(1'b0, 1'b0, 1'b0, 32'h0);
         drv_req(tbl[v].r, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC);
         smp();
         chk("gnt_hold", 32'(GNT_O), 32'(tbl[v].gnt));
         nxt(); smp();
         chk("release", 32'(GNT_O), 32'd0);
      end

      // 4-beat incrementing burst by requester 2 with a retried beat
      nxt(); drv_req(2, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF, CTI_INCR); smp();
      nxt(); smp();
      chk("burst_gnt0", 32'(GNT_O), 32'b0100);
      for (int b = 0; b < 5; b++) begin
         nxt();
         if (b == 2) begin
            brg(1'b0, 1'b1, 1'b0, 32'h0000_0100 + 32'(b));
            push(4'b0000, 4'b0100, 4'b0000, 32'h0000_0100 + 32'(b));
         end else begin
            brg(1'b1, 1'b0, 1'b0, 32'h0000_0100 + 32'(b));
            push(4'b0100, 4'b0000, 4'b0000, 32'h0000_0100 + 32'(b));
         end
         smp();
         chk("burst_gnt", 32'(GNT_O), 32'b0100);
         chk("burst_cti", 32'(bus.WBS_CTI_O), 32'(CTI_INCR));
      end
      nxt(); brg(1'b0, 1'b0, 1'b0, 32'h0);
      drv_req(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC); smp();
      nxt(); smp();
      chk("burst_release", 32'(GNT_O), 32'd0);
      chk("burst_sb_empty", 32'(exp_q.size()), 32'd0);

      // watchdog abort: requester 3 stalls, requester 0 waits behind it
      nxt(); drv_req(3, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, CTI_CLASSIC); smp();
      nxt(); smp();
      chk("to_gnt", 32'(GNT_O), 32'b1000);
      for (int s = 2; s <= 8; s++) begin
         nxt();
         if (s == 5) drv_req(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, CTI_CLASSIC);
         smp();
         chk("to_stall_cyc", 32'(bus.WBS_CYC_O), 32'd1);
         chk("to_stall_cnt", 32'(TIMEOUT_CNT_O), 32'd0);
      end
      nxt(); push(4'b0000, 4'b0000, 4'b1000, 32'h0); smp();
      chk("abort_cyc", 32'(bus.WBS_CYC_O), 32'd0);
      chk("abort_stb", 32'(bus.WBS_STB_O), 32'd0);
      chk("abort_cnt", 32'(TIMEOUT_CNT_O), 32'd1);
      chk("abort_err", 32'(bus.REQ_ERR_O), 32'b1000);
      nxt(); smp();
      chk("abort_err_once", 32'(bus.REQ_ERR_O), 32'd0);
      chk("abort_hold_gnt", 32'(GNT_O), 32'b1000);
      nxt(); drv_req(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC); smp();
      nxt(); smp();
      chk("abort_idle", 32'(GNT_O), 32'd0);
      nxt(); smp();
      chk("abort_next_owner", 32'(GNT_O), 32'b0001);
      nxt(); brg(1'b1, 1'b0, 1'b0, 32'h0000_0777); push(4'b0001, 4'b0000, 4'b0000, 32'h0000_0777); smp();
      nxt(); brg(1'b0, 1'b0, 1'b0, 32'h0);
      drv_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC); smp();
      nxt(); smp();
      chk("abort_next_release", 32'(GNT_O), 32'd0);

      // ACK lands in the expiry cycle: forwarded, no abort
      nxt(); drv_req(1, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF, CTI_CLASSIC); smp();
      nxt(); smp();
      chk("race_gnt", 32'(GNT_O), 32'b0010);
      for (int s = 2; s <= 7; s++) begin
         nxt(); smp();
      end
      nxt(); brg(1'b1, 1'b0, 1'b0, 32'h5A5A_0001); push(4'b0010, 4'b0000, 4'b0000, 32'h5A5A_0001); smp();
      chk("race_cyc", 32'(bus.WBS_CYC_O), 32'd1);
      nxt(); brg(1'b0, 1'b0, 1'b0, 32'h0);
      drv_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC); smp();
      chk("race_no_abort", 32'(GNT_O), 32'b0010);
      chk("race_cnt", 32'(TIMEOUT_CNT_O), 32'd1);
      nxt(); smp();
      chk("race_release", 32'(GNT_O), 32'd0);

      // reset during an owned burst, then all four request at once
      nxt(); drv_req(2, 1'b1, 1'b1, 32'h0000_6000, 32'h0000_0066, 4'hF, CTI_INCR); smp();
      nxt(); smp();
      chk("rstb_gnt", 32'(GNT_O), 32'b0100);
      nxt(); brg(1'b1, 1'b0, 1'b0, 32'h0000_0600); push(4'b0100, 4'b0000, 4'b0000, 32'h0000_0600); smp();
      nxt(); brg(1'b0, 1'b0, 1'b0, 32'h0); WB_RST_N = 1'b0; smp();
      nxt(); WB_RST_N = 1'b1;
      brg(1'b1, 1'b0, 1'b0, 32'h0000_0BAD);
      for (int r = 0; r < 4; r++) drv_req(r, 1'b1, 1'b0, 32'h0000_7000 + 32'(r), 32'h0, 4'hF, CTI_CLASSIC);
      smp();
      chk("rstb_gnt0",  32'(GNT_O), 32'd0);
      chk("rstb_cyc0",  32'(bus.WBS_CYC_O), 32'd0);
      chk("rstb_cnt0",  32'(TIMEOUT_CNT_O), 32'd0);
      chk("rstb_noack", 32'(bus.REQ_ACK_O), 32'd0);
      nxt(); brg(1'b0, 1'b0, 1'b0, 32'h0); smp();

      // round robin 0,1,2,3,0 with one idle cycle between owners
      for (int k = 0; k < 5; k++) begin
         chk("rr_gnt", 32'(GNT_O), 32'(4'b0001 << (k % 4)));
         nxt(); brg(1'b1, 1'b0, 1'b0, 32'h0000_A000 + 32'(k));
         push(4'(4'b0001 << (k % 4)), 4'b0000, 4'b0000, 32'h0000_A000 + 32'(k)); smp();
         nxt(); brg(1'b0, 1'b0, 1'b0, 32'h0);
         drv_req(k % 4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC); smp();
         nxt(); smp();
         chk("rr_idle", 32'(GNT_O), 32'd0);
         if (k < 4) drv_req(k % 4, 1'b1, 1'b0, 32'h0000_7000 + 32'(k), 32'h0, 4'hF, CTI_CLASSIC);
         nxt(); smp();
      end
      nxt();
      for (int r = 0; r < 4; r++) drv_req(r, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC);
      smp();
      nxt(); smp();
      chk("rr_end_idle", 32'(GNT_O), 32'd0);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wbs_pci_arbiter.md
Name: wbs_pci_arbiter

Overview:
- Round-robin arbiter sharing the PCI bridge's single WISHBONE slave port (the DMA path into PCI) between up to four local WISHBONE masters (DMA engines, register-init sequencer).
- Sits between the local masters and the bridge's WBS_* port, in the WB_CLK domain.
- Grants whole bus cycles, routes ACK/RTY/ERR back to the owner only, and aborts a hung cycle after a programmable cycle timeout.

Parameters:
NREQ, 4, number of requesters (2..4)
TIMEOUT_CYC, 1024, cycles of STB without ACK/RTY/ERR before abort; 0 disables the watchdog
TW, 11, width of timeout counter (>= clog2(TIMEOUT_CYC+1))

Ports:
WB_CLK  in  1  WISHBONE clock
WB_RST_N  in  1  reset; synchronous, active-low
REQ_CYC_I  in  NREQ  per-requester CYC
REQ_STB_I  in  NREQ  per-requester STB
REQ_WE_I  in  NREQ  per-requester WE
REQ_ADR_I  in  32*NREQ  flattened addresses, requester k at [32k+31:32k]
REQ_DAT_I  in  32*NREQ  flattened write data
REQ_SEL_I  in  4*NREQ  flattened byte selects
REQ_CTI_I  in  3*NREQ  flattened CTI
REQ_BTE_I  in  2*NREQ  flattened BTE
REQ_DAT_O  out  32  read data broadcast to all requesters
REQ_ACK_O  out  NREQ  per-requester ACK
REQ_RTY_O  out  NREQ  per-requester RTY
REQ_ERR_O  out  NREQ  per-requester ERR
WBS_ADR_O, WBS_DAT_O, WBS_SEL_O, WBS_CYC_O, WBS_STB_O, WBS_WE_O, WBS_CTI_O, WBS_BTE_O  out  32/32/4/1/1/1/3/2  to bridge slave port
WBS_DAT_I, WBS_ACK_I, WBS_RTY_I, WBS_ERR_I  in  32/1/1/1  from bridge slave port
GNT_O  out  NREQ  one-hot current owner (registered)
TIMEOUT_CNT_O  out  8  saturating count of aborted cycles

Behaviour:
- Reset (WB_RST_N=0 at a rising edge): state IDLE; GNT_O=0; priority pointer=0; timeout counter=0; TIMEOUT_CNT_O=0.
- While GNT_O=0: all WBS_* outputs 0; REQ_ACK/RTY/ERR_O=0. REQ_DAT_O = WBS_DAT_I always.
- States:
  - IDLE: if any REQ_CYC_I is high, grant the first requester at or after the pointer (cyclic). GNT_O is registered next cycle and state goes to OWNED.
  - OWNED: WBS_* outputs are combinationally muxed from the owner. Bridge ACK/RTY/ERR are routed combinationally to the owner's bit only.
    - When the owner drops CYC: clear GNT_O, set pointer = owner+1 mod NREQ, go to IDLE.
    - If the watchdog expires: go to ABORT.
  - ABORT: WBS_CYC_O/STB_O forced 0; owner's REQ_ERR_O=1 for exactly one cycle (the first ABORT cycle); TIMEOUT_CNT_O increments, saturating at 255. Stay until the owner drops CYC, then release as in OWNED.
- Grant latency: CYC rising at edge t gives GNT_O and bridge CYC at t+1. Back-to-back owners have one idle cycle between them (IDLE state).
- Ownership is never preempted. RTY ends only the beat; the owner keeps the grant until it drops CYC.
- Watchdog:
  - Counts OWNED cycles with WBS_STB_O=1 and none of ACK/RTY/ERR.
  - Clears on any ACK/RTY/ERR or when STB is low.
  - Expires when the count reaches TIMEOUT_CYC.
  - An ACK arriving in the expiry cycle wins: it is passed through and no abort occurs.
- A requester raising CYC while another owns the bus simply waits. Simultaneous requests are resolved by the pointer.
- Reset mid-cycle: WBS_CYC_O drops in the cycle after the reset edge. No ACK is forwarded after reset.

Decomposition:
- Shared package: WISHBONE CTI/BTE encodings, arbiter state encoding, helper for flattened-bus slice widths.
- One sub-module, rr_pick: combinational round-robin first-set-from-pointer selector (NREQ request bits + pointer -> one-hot grant).

Test Plan:
- Single request: requester 1 raises CYC/STB, ADR=0x0000_1000, WE=0; bridge ACKs with DAT=0xDEADBEEF two cycles later. Expected: GNT_O=0b0010 one cycle after CYC; REQ_ACK_O=0b0010 with REQ_DAT_O=0xDEADBEEF; other ACK bits 0.
- Round-robin, all four hold CYC continuously, single-beat cycles, each drops CYC after its ACK. Expected: grant order 0,1,2,3,0; one idle cycle between owners.
- Burst: owner 2 does a 4-beat CTI=010 burst with 1 RTY in the middle. Expected: grant is held through the RTY; the RTY is routed only to bit 2; all 4 ACKs are delivered.
- Timeout: TIMEOUT_CYC=8, bridge never responds. Expected:
  - the 8th STB cycle without response moves the arbiter to ABORT;
  - WBS_CYC_O=0 in ABORT;
  - REQ_ERR_O[owner] pulses exactly 1 cycle;
  - TIMEOUT_CNT_O goes 0->1;
  - a second owner is granted after the first drops CYC.
- Edge race: ACK arrives in the exact expiry cycle. Expected: ACK is forwarded, no ERR pulse, TIMEOUT_CNT_O unchanged.
- Reset mid-burst: WB_RST_N=0 for one edge during OWNED. Expected: GNT_O=0, WBS_CYC_O=0 and TIMEOUT_CNT_O=0 the next cycle; the pointer restarts at requester 0.
